// File: rtl/pc_fetch_pkg.sv
// Shared fetch-stage definitions: bus widths, zero word, state encoding.
// No timing behaviour; constants and helpers only.
package pc_fetch_pkg;

  localparam int INST_ADDR_BUS = 32;
  localparam int INST_BUS      = 32;

  localparam logic [INST_BUS-1:0]      ZERO_WORD = '0;
  localparam logic [INST_ADDR_BUS-1:0] PC_STEP   = INST_ADDR_BUS'(4);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_KILL  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [INST_ADDR_BUS-1:0] word_align(input logic [INST_ADDR_BUS-1:0] a);
    return {a[INST_ADDR_BUS-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch.sv
// Instruction fetch: holds pc/req_addr, issues one request per cycle, ack to if_valid_o is 1 cycle.
// stall_i freezes if_*; an ack that lands during a stall is parked in a one-entry skid buffer (HOLD).
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_BUS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     branch_flag_i,
  input  logic [INST_ADDR_BUS-1:0] branch_target_i,
  output logic                     imem_req_o,
  output logic [INST_ADDR_BUS-1:0] imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [INST_BUS-1:0]      imem_rdata_i,
  output logic [INST_ADDR_BUS-1:0] if_pc_o,
  output logic [INST_BUS-1:0]      if_inst_o,
  output logic                     if_valid_o
);

  fetch_state_e             state;
  logic [INST_ADDR_BUS-1:0] pc;
  logic [INST_ADDR_BUS-1:0] req_addr;
  logic [INST_ADDR_BUS-1:0] skid_pc;
  logic [INST_BUS-1:0]      skid_inst;
  logic                     ack_vld;
  logic [INST_ADDR_BUS-1:0] br_target;

  assign ack_vld     = imem_ack_i && imem_req_o;
  assign br_target   = word_align(branch_target_i);
  assign imem_addr_o = req_addr;

  // The skid buffer is full exactly when state is HOLD, so no separate valid flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      imem_req_o <= 1'b0;
      skid_pc    <= '0;
      skid_inst  <= ZERO_WORD;
      if_pc_o    <= '0;
      if_inst_o  <= ZERO_WORD;
      if_valid_o <= 1'b0;
    end else if (branch_flag_i) begin
      pc         <= br_target;
      if_valid_o <= 1'b0;
      if_inst_o  <= ZERO_WORD;
      skid_pc    <= '0;
      skid_inst  <= ZERO_WORD;
      imem_req_o <= 1'b1;
      // A request still in flight must be drained before the new address can go out.
      if ((state == ST_FETCH && imem_req_o && !ack_vld) ||
          (state == ST_KILL && !ack_vld)) begin
        state <= ST_KILL;
      end else begin
        state    <= ST_FETCH;
        req_addr <= br_target;
      end
    end else begin
      case (state)
        ST_FETCH: begin
          imem_req_o <= 1'b1;
          if (ack_vld) begin
            pc <= req_addr + PC_STEP;
            if (stall_i) begin
              skid_pc    <= req_addr;
              skid_inst  <= imem_rdata_i;
              imem_req_o <= 1'b0;
              state      <= ST_HOLD;
            end else begin
              if_pc_o    <= req_addr;
              if_inst_o  <= imem_rdata_i;
              if_valid_o <= 1'b1;
              req_addr   <= req_addr + PC_STEP;
            end
          end else if (!stall_i) begin
            if_valid_o <= 1'b0;
            if_inst_o  <= ZERO_WORD;
          end
        end
        ST_KILL: begin
          if (ack_vld) begin
            state    <= ST_FETCH;
            req_addr <= pc;
          end
          if (!stall_i) begin
            if_valid_o <= 1'b0;
            if_inst_o  <= ZERO_WORD;
          end
        end
        ST_HOLD: begin
          if (!stall_i) begin
            if_pc_o    <= skid_pc;
            if_inst_o  <= skid_inst;
            if_valid_o <= 1'b1;
            imem_req_o <= 1'b1;
            req_addr   <= pc;
            state      <= ST_FETCH;
          end
        end
        default: begin
          state      <= ST_FETCH;
          imem_req_o <= 1'b1;
          req_addr   <= pc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: memory returns inst_of(addr) unless overridden.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  logic        ovr_en = 1'b0;
  logic [31:0] ovr_dat = '0;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata_i = ovr_en ? ovr_dat : inst_of(imem_addr_o);

  pc_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_ack_i      (imem_ack_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic b, input logic [31:0] t, input logic a);
    stall_i         = s;
    branch_flag_i   = b;
    branch_target_i = t;
    imem_ack_i      = a;
  endtask

  // Leaves the DUT one edge past reset release: request up at RESET_PC.
  task automatic reset_release();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (2) step();
    rst = 1'b1;
    step();
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({tag, "_valid"}, {31'd0, if_valid_o}, {31'd0, v});
    chk({tag, "_pc"}, if_pc_o, p);
    chk({tag, "_inst"}, if_inst_o, i);
  endtask

  initial begin
    // Reset state, with ack held high to confirm it is ignored.
    rst = 1'b0;
    imem_ack_i = 1'b1;
    step();
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk_if("rst", 1'b0, 32'h0, 32'h0);

    // Ack every cycle from release; ack on the release edge is ignored (req low).
    reset_release();
    chk("a_req", {31'd0, imem_req_o}, 32'd1);
    chk("a_addr", imem_addr_o, 32'h0);
    chk("a_valid0", {31'd0, if_valid_o}, 32'd0);
    step(); chk_if("a0", 1'b1, 32'h0, inst_of(32'h0));
    step(); chk_if("a4", 1'b1, 32'h4, inst_of(32'h4));
    step(); chk_if("a8", 1'b1, 32'h8, inst_of(32'h8));
    step(); chk_if("a12", 1'b1, 32'hC, inst_of(32'hC));
    chk("a_addr16", imem_addr_o, 32'h10);

    // Ack every other cycle.
    reset_release();
    set_in(1'b0, 1'b0, 32'h0, 1'b1); step(); chk_if("b0", 1'b1, 32'h0, inst_of(32'h0));
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step(); chk_if("b0g", 1'b0, 32'h0, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1); step(); chk_if("b4", 1'b1, 32'h4, inst_of(32'h4));
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step(); chk_if("b4g", 1'b0, 32'h4, 32'h0);
    set_in(1'b0, 1'b0, 32'h0, 1'b1); step(); chk_if("b8", 1'b1, 32'h8, inst_of(32'h8));

    // Stall for 3 cycles while addr 8 is acked; stray ack during HOLD ignored.
    reset_release();
    set_in(1'b0, 1'b0, 32'h0, 1'b1); step(); step();
    chk_if("c4", 1'b1, 32'h4, inst_of(32'h4));
    chk("c_addr8", imem_addr_o, 32'h8);
    set_in(1'b1, 1'b0, 32'h0, 1'b1); step(); chk_if("c_st1", 1'b1, 32'h4, inst_of(32'h4));
    chk("c_req_hold", {31'd0, imem_req_o}, 32'd0);
    set_in(1'b1, 1'b0, 32'h0, 1'b1); step(); chk_if("c_st2", 1'b1, 32'h4, inst_of(32'h4));
    set_in(1'b1, 1'b0, 32'h0, 1'b0); step(); chk_if("c_st3", 1'b1, 32'h4, inst_of(32'h4));
    set_in(1'b0, 1'b0, 32'h0, 1'b0); step(); chk_if("c8", 1'b1, 32'h8, inst_of(32'h8));
    chk("c_req_back", {31'd0, imem_req_o}, 32'd1);
    chk("c_addr12", imem_addr_o, 32'hC);
    set_in(1'b0, 1'b0, 32'h0, 1'b1); step(); chk_if("c12", 1'b1, 32'hC, inst_of(32'hC));

    // Branch to 0x100 while request to 0x10 is pending; its ack (0xDEAD) is dropped.
    reset_release();
    set_in(1'b0, 1'b0, 32'h0, 1'b1); repeat (4) step();
    chk("d_addr10", imem_addr_o, 32'h10);
    set_in(1'b0, 1'b1, 32'h100, 1'b0); step();
    chk_if("d_br", 1'b0, 32'hC, 32'h0);
    chk("d_addr_kept", imem_addr_o, 32'h10);
    ovr_en = 1'b1; ovr_dat = 32'h0000_DEAD;
    set_in(1'b0, 1'b0, 32'h0, 1'b1); step();
    ovr_en = 1'b0;
    chk_if("d_drop", 1'b0, 32'hC, 32'h0);
    chk("d_addr100", imem_addr_o, 32'h100);
    step(); chk_if("d100", 1'b1, 32'h100, inst_of(32'h100));

    // Branch to misaligned 0x203 with simultaneous ack and stall.
    set_in(1'b1, 1'b1, 32'h203, 1'b1); step();
    chk("e_valid", {31'd0, if_valid_o}, 32'd0);
    chk("e_addr200", imem_addr_o, 32'h200);
    set_in(1'b0, 1'b0, 32'h0, 1'b1); step(); chk_if("e200", 1'b1, 32'h200, inst_of(32'h200));

    // Wrap-around at the top of the address space.
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0); step();
    set_in(1'b0, 1'b0, 32'h0, 1'b1); step();
    chk("f_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    step(); chk_if("f_top", 1'b1, 32'hFFFF_FFFC, inst_of(32'hFFFF_FFFC));
    chk("f_addr_wrap", imem_addr_o, 32'h0);
    step(); chk_if("f_wrap", 1'b1, 32'h0, inst_of(32'h0));

    // Asynchronous reset mid-request drops req at once; acks during reset ignored.
    #2 rst = 1'b0;
    #1;
    chk("g_req_async", {31'd0, imem_req_o}, 32'd0);
    chk("g_valid_async", {31'd0, if_valid_o}, 32'd0);
    step();
    chk("g_addr_rst", imem_addr_o, 32'h0);
    chk_if("g_rst", 1'b0, 32'h0, 32'h0);
    rst = 1'b1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
